// File: rtl/spi_target_pkg.sv
// Shared definitions for the 3-wire SPI register target.
// Holds the FSM state encoding, the 16-bit instruction header field
// positions and the W-field byte-count codes.
package spi_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    WR_DATA,
    RD_DATA,
    DONE
  } state_e;

  // Instruction header layout: {R/W, W1:W0, A12:A0}
  localparam int unsigned RW_BIT  = 15;
  localparam int unsigned W_MSB   = 14;
  localparam int unsigned W_LSB   = 13;
  localparam int unsigned HDR_LEN = 16;

  // Bit counter must reach HDR_LEN-1; data bytes reuse the same counter.
  localparam int unsigned HDR_CNT_W = $clog2(HDR_LEN);

  // W-field codes: number of data bytes in the transfer
  localparam logic [1:0] W_ONE    = 2'b00;
  localparam logic [1:0] W_TWO    = 2'b01;
  localparam logic [1:0] W_THREE  = 2'b10;
  localparam logic [1:0] W_STREAM = 2'b11;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizer plus edge detector for one asynchronous input.
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset (chain clears to 0)
//   din_i   asynchronous pin value
//   level_o synchronized level (SYNC_STAGES clk after the pin)
//   rise_o  one-cycle pulse on a synchronized 0->1 transition
//   fall_o  one-cycle pulse on a synchronized 1->0 transition
// SYNC_STAGES must be at least 2.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_3wire_target.sv
// 3-wire (shared SDIO) SPI responder, mode 0, MSB first.
// Decodes a 16-bit instruction header {R/W, W1:W0, A12:A0} and performs
// register-file writes or reads, decrementing the address after each byte.
// SCLK, CS_N and SDIO are oversampled on clk, which must run at least 12x SCLK.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   spi_sclk_i        SPI clock (CPOL=0)
//   spi_cs_n_i        chip select, active low
//   spi_sdio_i        SDIO pad input
//   spi_sdio_o        SDIO drive value, changed on SCLK fall
//   spi_sdio_oe       1 = target drives SDIO
//   reg_wr_en/addr/data  one-cycle write strobe with address and data
//   reg_rd_en/addr       one-cycle read strobe with address
//   reg_rd_data          read data, valid 1 clk after reg_rd_en
//   frame_err         pulse when CS_N rises mid-header or mid-byte
//   busy              high while a frame is in progress
module spi_3wire_target
  import spi_target_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_sdio_i,
  output logic                  spi_sdio_o,
  output logic                  spi_sdio_oe,
  output logic                  reg_wr_en,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_rd_en,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  frame_err,
  output logic                  busy
);

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic sdio_lvl;
  logic unused_sclk_lvl, unused_cs_lvl, unused_sdio_rise, unused_sdio_fall;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .din_i  (spi_sclk_i),
    .level_o(unused_sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // Chain resets to 0, so a CS_N already low when reset releases is not
  // mistaken for a fresh falling edge.
  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .din_i  (spi_cs_n_i),
    .level_o(unused_cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sdio (
    .clk    (clk),
    .rst    (rst),
    .din_i  (spi_sdio_i),
    .level_o(sdio_lvl),
    .rise_o (unused_sdio_rise),
    .fall_o (unused_sdio_fall)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [HDR_CNT_W-1:0]   bit_cnt_q;
  logic [HDR_LEN-1:0]     rx_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [1:0]             bytes_left_q;  // data bytes remaining after the current one
  logic                   stream_q;
  logic [DATA_WIDTH-1:0]  tx_q;
  logic                   ld_q;          // reg_rd_data is valid this cycle
  logic                   last_q;        // final read byte clocked, release SDIO on next fall

  logic                   sdio_o_q, sdio_oe_q;
  logic                   wr_en_q, rd_en_q, frame_err_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, rd_addr_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;

  logic [HDR_LEN-1:0]     rx_next;
  logic                   hdr_last_bit;
  logic                   byte_last_bit;
  logic                   final_byte;

  assign rx_next       = {rx_q[HDR_LEN-2:0], sdio_lvl};
  assign hdr_last_bit  = (bit_cnt_q == HDR_CNT_W'(HDR_LEN - 1));
  assign byte_last_bit = (bit_cnt_q == HDR_CNT_W'(DATA_WIDTH - 1));
  assign final_byte    = !stream_q && (bytes_left_q == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      addr_q       <= '0;
      bytes_left_q <= '0;
      stream_q     <= 1'b0;
      tx_q         <= '0;
      ld_q         <= 1'b0;
      last_q       <= 1'b0;
      sdio_o_q     <= 1'b0;
      sdio_oe_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      ld_q        <= rd_en_q;
      if (ld_q) begin
        tx_q <= reg_rd_data;
      end

      if (cs_rise) begin
        // CS_N rise outranks any SCLK edge seen in the same cycle.
        if (state_q == INSTR) begin
          frame_err_q <= 1'b1;
        end else if ((state_q == WR_DATA || state_q == RD_DATA) && bit_cnt_q != '0) begin
          frame_err_q <= 1'b1;
        end
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        last_q    <= 1'b0;
        ld_q      <= 1'b0;
        sdio_oe_q <= 1'b0;
        sdio_o_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (cs_fall) begin
              state_q   <= INSTR;
              bit_cnt_q <= '0;
            end
          end

          INSTR: begin
            if (sclk_rise) begin
              rx_q <= rx_next;
              if (hdr_last_bit) begin
                bit_cnt_q    <= '0;
                addr_q       <= rx_next[ADDR_WIDTH-1:0];
                bytes_left_q <= rx_next[W_MSB:W_LSB];
                stream_q     <= (rx_next[W_MSB:W_LSB] == W_STREAM);
                if (rx_next[RW_BIT]) begin
                  state_q   <= RD_DATA;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= rx_next[ADDR_WIDTH-1:0];
                end else begin
                  state_q <= WR_DATA;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + HDR_CNT_W'(1);
              end
            end
          end

          WR_DATA: begin
            if (sclk_rise) begin
              rx_q <= rx_next;
              if (byte_last_bit) begin
                bit_cnt_q <= '0;
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= rx_next[DATA_WIDTH-1:0];
                addr_q    <= addr_q - ADDR_WIDTH'(1);
                if (final_byte) begin
                  state_q <= DONE;
                end else if (!stream_q) begin
                  bytes_left_q <= bytes_left_q - 2'd1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + HDR_CNT_W'(1);
              end
            end
          end

          RD_DATA: begin
            if (sclk_rise) begin
              if (byte_last_bit) begin
                bit_cnt_q <= '0;
                if (final_byte) begin
                  last_q <= 1'b1;
                end else begin
                  // Prefetch the next byte so it is loaded before the next fall.
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= addr_q - ADDR_WIDTH'(1);
                  addr_q    <= addr_q - ADDR_WIDTH'(1);
                  if (!stream_q) begin
                    bytes_left_q <= bytes_left_q - 2'd1;
                  end
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + HDR_CNT_W'(1);
              end
            end else if (sclk_fall) begin
              if (last_q) begin
                last_q    <= 1'b0;
                sdio_oe_q <= 1'b0;
                sdio_o_q  <= 1'b0;
                state_q   <= DONE;
              end else begin
                sdio_oe_q <= 1'b1;
                sdio_o_q  <= tx_q[DATA_WIDTH-1];
                tx_q      <= tx_q << 1;
              end
            end
          end

          DONE: begin
            sdio_oe_q <= 1'b0;
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign spi_sdio_o  = sdio_o_q;
  assign spi_sdio_oe = sdio_oe_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_en   = rd_en_q;
  assign reg_rd_addr = rd_addr_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_3wire_target.sv
// Bench for spi_3wire_target: table of directed frames, a reset-mid-read
// sequence and random frames, all checked against a transaction-level model.
module tb_spi_3wire_target;

  localparam int HALF = 8;  // clk cycles per SCLK half period (SCLK = clk/16)

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk_i, spi_cs_n_i, spi_sdio_i;
  logic        spi_sdio_o, spi_sdio_oe;
  logic        reg_wr_en, reg_rd_en, frame_err, busy;
  logic [12:0] reg_wr_addr, reg_rd_addr;
  logic [7:0]  reg_wr_data, reg_rd_data;

  always #5 clk = ~clk;

  spi_3wire_target dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sclk_i (spi_sclk_i),
    .spi_cs_n_i (spi_cs_n_i),
    .spi_sdio_i (spi_sdio_i),
    .spi_sdio_o (spi_sdio_o),
    .spi_sdio_oe(spi_sdio_oe),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Register file model: read data valid one clk after the strobe.
  logic [7:0] mem [0:8191];
  always @(posedge clk or posedge rst) begin
    if (rst) reg_rd_data <= 8'h00;
    else if (reg_rd_en) reg_rd_data <= mem[reg_rd_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitors
  logic [12:0] wr_addr_log[$];
  logic [7:0]  wr_data_log[$];
  logic [12:0] rd_addr_log[$];
  int          ferr_cnt;
  int          oe_bad;
  bit          no_oe;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_addr_log.push_back(reg_wr_addr);
      wr_data_log.push_back(reg_wr_data);
    end
    if (reg_rd_en) rd_addr_log.push_back(reg_rd_addr);
    if (frame_err) ferr_cnt++;
    if (no_oe && spi_sdio_oe) oe_bad++;
  end

  logic [7:0] wdat [8];
  logic       rx_bit [64];
  logic       rx_oe [64];

  task automatic sclk_half();
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  // Drives one frame as the master. rst_bit >= 0 asserts reset during the
  // low phase of that data bit and abandons the frame.
  task automatic run_frame(input logic [15:0] hdr, input int hdr_bits, input int data_bits,
                           input int rst_bit);
    bit aborted = 0;
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_addr_log.delete();
    ferr_cnt = 0;
    oe_bad   = 0;
    no_oe    = 1;
    spi_cs_n_i = 1'b0;
    sclk_half();
    for (int b = 0; b < hdr_bits; b++) begin
      spi_sdio_i = hdr[15-b];
      sclk_half();
      spi_sclk_i = 1'b1;
      sclk_half();
      spi_sclk_i = 1'b0;
    end
    no_oe = !(hdr[15] && hdr_bits >= 16);
    for (int j = 0; j < data_bits; j++) begin
      if (hdr[15]) spi_sdio_i = 1'($urandom);
      else spi_sdio_i = wdat[j/8][7-(j%8)];
      sclk_half();
      rx_bit[j] = spi_sdio_o;
      rx_oe[j]  = spi_sdio_oe;
      if (j == rst_bit) begin
        check("oe before mid-read reset", spi_sdio_oe, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("reset clears oe", spi_sdio_oe, 1'b0);
        check("reset clears rd_en", reg_rd_en, 1'b0);
        check("reset clears wr_en", reg_wr_en, 1'b0);
        check("reset clears busy", busy, 1'b0);
        check("reset clears sdio_o", spi_sdio_o, 1'b0);
        spi_cs_n_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        aborted = 1;
        break;
      end
      spi_sclk_i = 1'b1;
      sclk_half();
      spi_sclk_i = 1'b0;
    end
    if (!aborted) begin
      sclk_half();
      check("busy before CS_N rise", busy, 1'b1);
      spi_cs_n_i = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("busy after CS_N rise", busy, 1'b0);
      check("oe after CS_N rise", spi_sdio_oe, 1'b0);
    end
    no_oe = 1;
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: what a frame of this shape must produce.
  task automatic check_frame(input logic [15:0] hdr, input int hdr_bits, input int data_bits);
    bit          rw, stream, done;
    int          n, k, nbytes, nw, nr, bad_oe, bad_bit;
    logic        exp_ferr, exp_oe;
    logic [12:0] start, a;
    rw     = hdr[15];
    stream = (hdr[14:13] == 2'b11);
    n      = int'(hdr[14:13]) + 1;
    start  = hdr[12:0];
    k      = data_bits / 8;
    if (hdr_bits < 16) begin
      nw = 0; nr = 0; exp_ferr = 1'b1;
    end else begin
      done     = !stream && k >= n;
      nbytes   = stream ? k : ((k < n) ? k : n);
      exp_ferr = (data_bits % 8 != 0) && !done;
      nw       = rw ? 0 : nbytes;
      nr       = rw ? 1 + (stream ? k : ((k < n - 1) ? k : n - 1)) : 0;
    end
    check("frame_err pulses", ferr_cnt, 32'(exp_ferr));
    check("write strobe count", wr_addr_log.size(), nw);
    for (int i = 0; i < nw; i++) begin
      a = start - 13'(i);
      check("write addr", (i < wr_addr_log.size()) ? wr_addr_log[i] : 'x, a);
      check("write data", (i < wr_data_log.size()) ? wr_data_log[i] : 'x, wdat[i]);
    end
    check("read strobe count", rd_addr_log.size(), nr);
    for (int i = 0; i < nr; i++) begin
      a = start - 13'(i);
      check("read addr", (i < rd_addr_log.size()) ? rd_addr_log[i] : 'x, a);
    end
    if (rw && hdr_bits >= 16) begin
      bad_oe  = 0;
      bad_bit = 0;
      for (int j = 0; j < data_bits; j++) begin
        exp_oe = stream || (j / 8 < n);
        if (rx_oe[j] !== exp_oe) bad_oe++;
        if (exp_oe) begin
          a = start - 13'(j / 8);
          if (rx_bit[j] !== mem[a][7-(j%8)]) bad_bit++;
        end
      end
      check("sdio oe per data bit", bad_oe, 0);
      check("sdio data per bit", bad_bit, 0);
    end
    check("oe outside read data", oe_bad, 0);
  endtask

  typedef struct {
    logic [15:0] hdr;
    int          hdr_bits;
    int          data_bits;
    logic [31:0] wbytes;
    int          exp_nwr;
    int          exp_nrd;
    int          exp_ferr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hdr;
    int          nbits;

    vecs[0] = '{16'h0010, 16, 8,  32'hA500_0000, 1, 0, 0};  // single write
    vecs[1] = '{16'h40FF, 16, 32, 32'h1122_3344, 3, 0, 0};  // 3 bytes + 8 extra SCLKs
    vecs[2] = '{16'h8003, 16, 8,  32'h0,         0, 1, 0};  // single read
    vecs[3] = '{16'hE001, 16, 24, 32'h0,         0, 4, 0};  // stream read wrap
    vecs[4] = '{16'h0020, 16, 5,  32'hFF00_0000, 0, 0, 1};  // abort mid-byte
    vecs[5] = '{16'h0030, 16, 8,  32'h3C00_0000, 1, 0, 0};  // write after abort
    vecs[6] = '{16'hC105, 16, 28, 32'h0,         0, 3, 0};  // 3-byte read, bits past DONE
    vecs[7] = '{16'h2000, 10, 0,  32'h0,         0, 0, 1};  // short header

    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[3] = 8'h5C;

    rst = 1'b1;
    spi_sclk_i = 1'b0;
    spi_cs_n_i = 1'b1;
    spi_sdio_i = 1'b0;
    no_oe = 1;
    ferr_cnt = 0;
    oe_bad = 0;
    repeat (4) @(posedge clk);
    #1;
    check("reset oe", spi_sdio_oe, 1'b0);
    check("reset sdio_o", spi_sdio_o, 1'b0);
    check("reset wr_en", reg_wr_en, 1'b0);
    check("reset rd_en", reg_rd_en, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset wr_addr", reg_wr_addr, 13'h0);
    check("reset rd_addr", reg_rd_addr, 13'h0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      for (int b = 0; b < 4; b++) wdat[b] = vecs[i].wbytes[31-8*b -: 8];
      run_frame(vecs[i].hdr, vecs[i].hdr_bits, vecs[i].data_bits, -1);
      check($sformatf("vec%0d write count", i), wr_addr_log.size(), vecs[i].exp_nwr);
      check($sformatf("vec%0d read count", i), rd_addr_log.size(), vecs[i].exp_nrd);
      check($sformatf("vec%0d frame_err", i), ferr_cnt, vecs[i].exp_ferr);
      if (rd_addr_log.size() > 2 && vecs[i].hdr == 16'hE001) begin
        check("stream wrap addr", rd_addr_log[2], 13'h1FFF);
      end
      check_frame(vecs[i].hdr, vecs[i].hdr_bits, vecs[i].data_bits);
    end

    // Reset during the 4th data bit of a read, then a clean read.
    run_frame(16'h8003, 16, 8, 3);
    check("no frame_err on reset abort", ferr_cnt, 0);
    run_frame(16'h8003, 16, 8, -1);
    check_frame(16'h8003, 16, 8);

    // Random frames
    for (int r = 0; r < 24; r++) begin
      hdr   = 16'($urandom);
      nbits = 8 * $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) nbits += $urandom_range(1, 7);
      for (int b = 0; b < 8; b++) wdat[b] = 8'($urandom);
      run_frame(hdr, 16, nbits, -1);
      check_frame(hdr, 16, nbits);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
